// File: rtl/alu_word_pkg.sv
// Shared encodings for the 16-bit word-op sequencer in front of the 8-bit ALU.
// Contents: word-op codes, ALU op codes, sequencer states, flag bit positions,
// and small decode helpers used by alu_word_seq.
package alu_word_pkg;

    // Word operation codes (wop input)
    localparam logic [2:0] WOP_INW  = 3'b000;
    localparam logic [2:0] WOP_DEW  = 3'b001;
    localparam logic [2:0] WOP_ASW  = 3'b010;
    localparam logic [2:0] WOP_ROW  = 3'b011;
    localparam logic [2:0] WOP_LSRW = 3'b100;
    localparam logic [2:0] WOP_RORW = 3'b101;
    localparam logic [2:0] WOP_ASRW = 3'b110;
    localparam logic [2:0] WOP_ADDW = 3'b111;

    // ALU op codes: op[3:2] picks the B-side operand, op[1:0] = 11 passes AI
    localparam logic [3:0] ALU_ADD  = 4'b0011;  // AI + BI + CI
    localparam logic [3:0] ALU_SUB  = 4'b0111;  // AI + ~BI + CI
    localparam logic [3:0] ALU_DBL  = 4'b1011;  // AI + AI + CI
    localparam logic [3:0] ALU_PASS = 4'b1111;  // AI + 0 + CI, or shift when right=1

    // Positions within flags / flag_we, packed as {N,V,Z,C}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFirst  = 2'd1,
        StSecond = 2'd2,
        StLast   = 2'd3
    } state_t;

    // Right shifts walk the word high byte first so the carry moves downward.
    function automatic logic is_right_op(input logic [2:0] op);
        return (op == WOP_LSRW) || (op == WOP_RORW) || (op == WOP_ASRW);
    endfunction

    // Which status flags the op is allowed to update.
    function automatic logic [3:0] flag_mask(input logic [2:0] op);
        logic [3:0] m;
        m = '0;
        m[FLAG_N] = 1'b1;
        m[FLAG_Z] = 1'b1;
        if (op == WOP_ADDW) begin
            m[FLAG_V] = 1'b1;
        end
        if ((op != WOP_INW) && (op != WOP_DEW)) begin
            m[FLAG_C] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/alu_word_seq.sv
// Multi-cycle sequencer running 16-bit word ops through the 8-bit ALU one byte
// at a time, then assembling the word result and {N,V,Z,C} flags with a write mask.
// Ports:
//   clk, reset (async, active-high), RDY (global stall, low freezes all state)
//   start/wop/opa/opb/c_in : request, accepted only when idle and RDY=1
//   busy, done (one-cycle pulse), result, flags, flag_we : outputs
//   alu_op/right/arith/AI/BI/CI/BCD : drive to ALU; alu_OUT/CO/V : registered ALU results
module alu_word_seq
    import alu_word_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        RDY,
    input  logic        start,
    input  logic [2:0]  wop,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic [3:0]  flag_we,
    output logic [3:0]  alu_op,
    output logic        alu_right,
    output logic        alu_arith,
    output logic [7:0]  alu_AI,
    output logic [7:0]  alu_BI,
    output logic        alu_CI,
    output logic        alu_BCD,
    input  logic [7:0]  alu_OUT,
    input  logic        alu_CO,
    input  logic        alu_V
);

    state_t      state_q;
    logic [2:0]  wop_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic        cin_q;
    logic [7:0]  byte0_q;
    logic        done_q;
    logic [15:0] result_q;
    logic [3:0]  flags_q;
    logic [3:0]  flag_we_q;

    logic        second;
    logic        use_hi;
    logic        ci_first;
    logic [15:0] word;

    // byte0_q holds the first-processed byte; alu_OUT in LAST is the second one
    assign word = is_right_op(wop_q) ? {byte0_q, alu_OUT} : {alu_OUT, byte0_q};

    // Per-op ALU drive for the two byte cycles; idle values otherwise.
    always_comb begin
        alu_op    = ALU_PASS;
        alu_right = 1'b0;
        alu_arith = 1'b0;
        alu_AI    = 8'h00;
        alu_BI    = 8'h00;
        alu_CI    = 1'b0;
        second    = (state_q == StSecond);
        use_hi    = second ^ is_right_op(wop_q);
        ci_first  = 1'b0;
        if ((state_q == StFirst) || (state_q == StSecond)) begin
            alu_AI = use_hi ? opa_q[15:8] : opa_q[7:0];
            unique case (wop_q)
                WOP_INW: begin
                    alu_op   = ALU_ADD;
                    ci_first = 1'b1;
                end
                WOP_DEW: begin
                    alu_op = ALU_SUB;
                end
                WOP_ASW: begin
                    alu_op = ALU_DBL;
                end
                WOP_ROW: begin
                    alu_op   = ALU_DBL;
                    ci_first = cin_q;
                end
                WOP_ADDW: begin
                    alu_op   = ALU_ADD;
                    alu_BI   = use_hi ? opb_q[15:8] : opb_q[7:0];
                    ci_first = cin_q;
                end
                WOP_LSRW: begin
                    alu_right = 1'b1;
                end
                WOP_RORW: begin
                    alu_right = 1'b1;
                    ci_first  = cin_q;
                end
                WOP_ASRW: begin
                    alu_right = 1'b1;
                    // Only the high byte replicates the sign; the low byte takes
                    // the high byte's bit0 through CI.
                    alu_arith = !second;
                end
            endcase
            // Second byte chains on the first byte's carry, registered by the ALU
            alu_CI = second ? alu_CO : ci_first;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wop_q     <= 3'b000;
            opa_q     <= 16'h0000;
            opb_q     <= 16'h0000;
            cin_q     <= 1'b0;
            byte0_q   <= 8'h00;
            done_q    <= 1'b0;
            result_q  <= 16'h0000;
            flags_q   <= 4'h0;
            flag_we_q <= 4'h0;
        end else if (RDY) begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        wop_q   <= wop;
                        opa_q   <= opa;
                        opb_q   <= opb;
                        cin_q   <= c_in;
                        state_q <= StFirst;
                    end
                end
                StFirst: begin
                    state_q <= StSecond;
                end
                StSecond: begin
                    byte0_q <= alu_OUT;
                    state_q <= StLast;
                end
                StLast: begin
                    result_q          <= word;
                    flags_q[FLAG_N]   <= word[15];
                    flags_q[FLAG_V]   <= (wop_q == WOP_ADDW) && alu_V;
                    flags_q[FLAG_Z]   <= (word == 16'h0000);
                    flags_q[FLAG_C]   <= alu_CO;
                    flag_we_q         <= flag_mask(wop_q);
                    done_q            <= 1'b1;
                    state_q           <= StIdle;
                end
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    // A stalled done cycle must not report done; it shows once RDY returns.
    assign done    = done_q && RDY;
    assign result  = result_q;
    assign flags   = flags_q;
    assign flag_we = flag_we_q;
    assign alu_BCD = 1'b0;

endmodule

// File: doc/alu_word_seq.md
Name: alu_word_seq

Overview:
Multi-cycle sequencer for the 65CE02 16-bit word operations: INW, DEW, ASW, ROW, plus the team's word right-shifts and ADDW.
- Sits directly upstream of the 8-bit ALU (alu_65ce02). It drives that ALU's op/right/arith/AI/BI/CI/BCD inputs one byte at a time.
- It consumes the ALU's registered OUT/CO/V back.
- It assembles the 16-bit result and the N/V/Z/C flags with a per-flag write mask for the status register.

Parameters:
none (widths fixed: 8-bit ALU, 16-bit word)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
RDY  in  1  global stall, shared with the ALU; low freezes all state
start  in  1  request; accepted only in IDLE with RDY=1
wop  in  3  word op: 000 INW, 001 DEW, 010 ASW, 011 ROW, 100 LSRW, 101 RORW, 110 ASRW, 111 ADDW
opa  in  16  operand A
opb  in  16  operand B (ADDW only)
c_in  in  1  current carry flag (ROW, RORW, ADDW)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse; result/flags valid
result  out  16  word result, held until next done
flags  out  4  {N,V,Z,C}
flag_we  out  4  {N,V,Z,C} update mask, valid with done
alu_op  out  4  to ALU op
alu_right  out  1  to ALU right
alu_arith  out  1  to ALU arith
alu_AI  out  8  to ALU AI
alu_BI  out  8  to ALU BI
alu_CI  out  1  to ALU CI
alu_BCD  out  1  to ALU BCD, constant 0
alu_OUT  in  8  from ALU OUT (registered in ALU)
alu_CO  in  1  from ALU CO
alu_V  in  1  from ALU V

Behaviour:
- States:
  - IDLE -> FIRST -> SECOND -> LAST -> IDLE.
  - Every transition, capture and the done pulse are qualified by RDY. With RDY=0 everything holds and done=0.
- IDLE:
  - ALU drive = op 1111, right 0, AI 0, BI 0, CI 0.
  - On start&RDY: latch wop, opa, opb, c_in; go to FIRST.
  - start while busy is ignored, with no queueing.
- Byte order:
  - Left ops (INW, DEW, ASW, ROW, ADDW): FIRST = low byte, SECOND = high byte.
  - Right ops (LSRW, RORW, ASRW): FIRST = high byte, SECOND = low byte.
- FIRST drive (CI_f):
  - INW: op 0011, BI 00, CI 1.
  - DEW: op 0111, BI 00, CI 0.
  - ASW: op 1011, CI 0.
  - ROW: op 1011, CI c_in.
  - ADDW: op 0011, BI opb lo, CI c_in.
  - LSRW: op 1111, right 1, CI 0.
  - RORW: op 1111, right 1, CI c_in.
  - ASRW: op 1111, right 1, arith 1.
- SECOND drive:
  - Same op with the other byte (BI = opb hi for ADDW).
  - CI = alu_CO. alu_CO is the FIRST-byte carry; it is registered by the ALU at the end of FIRST.
  - ASRW second byte: arith 0, so the high byte's bit0 shifts in.
  - Capture alu_OUT -> byte0 register.
- LAST:
  - ALU drive returns to idle values. alu_OUT/alu_CO/alu_V are the SECOND-byte results.
  - Registered on RDY: result = assembled word; done <= 1 (next cycle, in IDLE).
- Latency: start accepted at cycle 0 -> done=1 at cycle 4. A new start may be accepted in the done cycle, giving one op per 4 cycles.
- Flags:
  - N = result[15]; Z = (result == 0), across both bytes.
  - C = final alu_CO.
  - V = alu_V from the high byte (ADDW only), else 0.
- flag_we:
  - INW/DEW: N,Z.
  - Shifts/rotates: N,Z,C.
  - ADDW: N,V,Z,C.
- Wrap: INW FFFF -> 0000 (Z=1); DEW 0000 -> FFFF (N=1). Carry is not written for either.
- Reset (any time, including mid-op):
  - Immediately: state IDLE; busy, done, result, flags, flag_we = 0; ALU drive = idle values.
  - An in-flight op is dropped and no done occurs.

Decomposition:
- Package alu_word_pkg holds:
  - WOP_* encodings.
  - ALU op constants: ALU_ADD 0011, ALU_SUB 0111, ALU_DBL 1011, ALU_PASS 1111.
  - State encoding.
  - Flag bit indices.
- Single module; no sub-module warranted. The per-op FIRST/SECOND drive table is one combinational case.

Test Plan:
- INW opa=00FF -> done at cycle 4; result=0100; flags N0 Z0; flag_we={1,0,1,0}. INW FFFF -> 0000, Z=1.
- DEW opa=0000 -> result=FFFF, N=1, Z=0, flag_we={1,0,1,0}.
- ASW opa=8001 c_in=1 -> 0002, C=1. ROW opa=8001 c_in=1 -> 0003, C=1.
- RORW opa=0001 c_in=1 -> 8000, C=1, N=1. ASRW 8002 -> C001, C=0. LSRW 8002 -> 4001, C=0.
- ADDW 7FFF+0001 c_in=0 -> 8000, V=1, N=1, C=0. ADDW FFFF+0001 -> 0000, C=1, Z=1.
- Stall and reset:
  - RDY=0 for 3 cycles in SECOND -> ALU drive and state frozen; done delayed exactly 3 cycles.
  - reset pulse in SECOND -> busy=0, result=0000, no done pulse.
  - start during busy -> ignored.
